sdram_wb_bridge: RTL



---
 rtl/sdram_wb_bridge_if.sv | 20 ++
 rtl/sdram_wb_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_bridge_if.sv
// Wishbone-style memory port between the kernel bus master and the SDRAM bridge.
interface sdram_wb_bridge_if;
   logic        wb_stb;
   logic        wb_we;
   logic [1:0]  wb_sel;
   logic [21:1] wb_adr;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack;

   modport master (
      output wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
      input  wb_dat_o, wb_ack
   );

   modport slave (
      input  wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
      output wb_dat_o, wb_ack
   );
endinterface

// File: rtl/sdram_wb_bridge.sv
// Bus front end of the SDRAM subsystem: latches a Wishbone transaction, holds a
// wr/rd request level to the controller until its acknowledge or a timeout.
module sdram_wb_bridge #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned SYNC    = 1
) (
   input  logic                    clk_p,
   input  logic                    sdram_reset,
   sdram_wb_bridge_if.slave        bus,
   input  logic                    ctl_ready,
   output logic                    ctl_wr_req,
   output logic                    ctl_rd_req,
   input  logic                    ctl_wr_ack,
   input  logic                    ctl_rd_ack,
   output logic [21:0]             ctl_addr,
   output logic [15:0]             ctl_wdata,
   input  logic [15:0]             ctl_rdata,
   output logic [1:0]              ctl_byteen,
   output logic                    dqm_h,
   output logic                    dqm_l,
   output logic                    timeout_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [20:0] adr_q, adr_d;
   logic [15:0] wdat_q, wdat_d;
   logic [1:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        wr_req_q, wr_req_d;
   logic        rd_req_q, rd_req_d;
   logic        ack_q, ack_d;
   logic [15:0] rdat_q, rdat_d;
   logic        dqm_h_q, dqm_h_d;
   logic        dqm_l_q, dqm_l_d;
   logic        terr_q, terr_d;
   logic        wr_sync, rd_sync;
   logic        wr_prev_q, rd_prev_q;
   logic        ack_evt;

   if (SYNC != 0) begin : g_sync2
      logic [1:0] wr_ff_q, rd_ff_q;
      always_ff @(posedge clk_p) begin
         if (sdram_reset) begin
            wr_ff_q <= '0;
            rd_ff_q <= '0;
         end else begin
            wr_ff_q <= {wr_ff_q[0], ctl_wr_ack};
            rd_ff_q <= {rd_ff_q[0], ctl_rd_ack};
         end
      end
      assign wr_sync = wr_ff_q[1];
      assign rd_sync = rd_ff_q[1];
   end else begin : g_sync1
      logic wr_ff_q, rd_ff_q;
      always_ff @(posedge clk_p) begin
         if (sdram_reset) begin
            wr_ff_q <= 1'b0;
            rd_ff_q <= 1'b0;
         end else begin
            wr_ff_q <= ctl_wr_ack;
            rd_ff_q <= ctl_rd_ack;
         end
      end
      assign wr_sync = wr_ff_q;
      assign rd_sync = rd_ff_q;
   end

   // Only the ack matching the latched direction can complete the transaction.
   assign ack_evt = we_q ? (wr_sync & ~wr_prev_q) : (rd_sync & ~rd_prev_q);

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      sel_d    = sel_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      wr_req_d = 1'b0;
      rd_req_d = 1'b0;
      rdat_d   = rdat_q;
      dqm_h_d  = dqm_h_q;
      dqm_l_d  = dqm_l_q;
      terr_d   = terr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.wb_stb && ctl_ready) begin
               adr_d   = bus.wb_adr;
               wdat_d  = bus.wb_dat_i;
               sel_d   = bus.wb_sel;
               we_d    = bus.wb_we;
               cnt_d   = '0;
               dqm_h_d = bus.wb_we & ~bus.wb_sel[1];
               dqm_l_d = bus.wb_we & ~bus.wb_sel[0];
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + 8'd1;
            // Requests are registered from the REQ state, so they fall on the
            // same edge that wb_ack rises.
            if (ack_evt) begin
               state_d = ST_DONE;
               if (!we_q) rdat_d = ctl_rdata;
            end else if (cnt_q == TO_LAST) begin
               state_d = ST_DONE;
               terr_d  = 1'b1;
               if (!we_q) rdat_d = '1;
            end else begin
               wr_req_d = we_q;
               rd_req_d = ~we_q;
            end
         end
         ST_DONE: begin
            if (!bus.wb_stb) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      ack_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_p) begin
      if (sdram_reset) begin
         state_q   <= ST_IDLE;
         adr_q     <= '0;
         wdat_q    <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         cnt_q     <= '0;
         wr_req_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         ack_q     <= 1'b0;
         rdat_q    <= '0;
         dqm_h_q   <= 1'b0;
         dqm_l_q   <= 1'b0;
         terr_q    <= 1'b0;
         wr_prev_q <= 1'b0;
         rd_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         cnt_q     <= cnt_d;
         wr_req_q  <= wr_req_d;
         rd_req_q  <= rd_req_d;
         ack_q     <= ack_d;
         rdat_q    <= rdat_d;
         dqm_h_q   <= dqm_h_d;
         dqm_l_q   <= dqm_l_d;
         terr_q    <= terr_d;
         wr_prev_q <= wr_sync;
         rd_prev_q <= rd_sync;
      end
   end

   assign bus.wb_ack   = ack_q;
   assign bus.wb_dat_o = rdat_q;
   assign ctl_wr_req   = wr_req_q;
   assign ctl_rd_req   = rd_req_q;
   assign ctl_addr     = {1'b0, adr_q};
   assign ctl_wdata    = wdat_q;
   assign ctl_byteen   = sel_q;
   assign dqm_h        = dqm_h_q;
   assign dqm_l        = dqm_l_q;
   assign timeout_err  = terr_q;

endmodule
